binarize_ctrl: RTL and testbench
================================

// Module: binarize_ctrl
// PURPOSE
// Sequencer for the histogram-threshold binarization datapath. Per frame it clears the 256-bin
// counter bank, then streams pass-1 pixels into it as one-hot bin enables. It then waits for the
// CDF-compare / 256-to-8 priority-encoder chain to settle and latches its code as the threshold.
// It then streams pass-2 pixels out as binary pixels. One frame in flight at a time.
// PARAMETERS
// FRAME_PIXELS  4096  pixels per frame (per pass); elaboration error if >= 2**CNT_W or == 0
// CNT_W         14    width of each bin counter in the counter bank
// CLR_CYCLES    2     cycles cnt_clear is held high (>=1)
// SEARCH_LAT    3     cycles from last bin update until thr_code is valid (>=1)
// PORTS
// clk          in   1    clock, all logic rising-edge
// clear_n      in   1    asynchronous active-low reset
// start        in   1    begin a frame; sampled only in IDLE
// pix_valid    in   1    input pixel valid (both passes)
// pix_data     in   8    input pixel value
// pix_ready    out  1    input pixel accepted when pix_valid & pix_ready
// cnt_clear    out  1    clear to counter bank
// cnt_inc_en   out  256  one-hot bin enable to counter bank (bit k = increment bin k)
// thr_code     in   8    threshold bin from priority encoder
// out_valid    out  1    binary pixel valid
// out_bit      out  1    binary pixel: 1 iff pixel >= threshold
// out_ready    in   1    downstream accepts when out_valid & out_ready
// threshold    out  8    latched threshold for current/last frame
// busy         out  1    high in every state except IDLE
// done         out  1    one-cycle pulse when the last binary pixel is accepted
// BEHAVIOUR
// - Reset (async, clear_n=0): state IDLE; all outputs 0 (threshold=0, cnt_inc_en=0). Reset
//   mid-frame aborts at once; counters are not cleared by this block until the next start.
// - Pixel counter: $clog2(FRAME_PIXELS+1) bits; cleared on each pass entry, +1 per handshake.
// - IDLE: pix_ready=0. start=1 -> CLEAR. start is ignored in all other states.
// - CLEAR: cnt_clear=1 for exactly CLR_CYCLES cycles -> ACCUM.
// - ACCUM: pix_ready=1. On each handshake the cnt_inc_en bit for pix_data is registered and driven
//   high for exactly 1 cycle, the cycle after acceptance. Back-to-back pixels give back-to-back
//   one-hot vectors, never more than 1 bit set. After the FRAME_PIXELS-th handshake,
//   pix_ready=0 next cycle -> FLUSH.
// - FLUSH: 1 cycle for the final cnt_inc_en to land -> SEARCH.
// - SEARCH: wait SEARCH_LAT cycles. Sample thr_code into threshold on the last cycle -> BIN.
// - BIN: output register is 1 deep. pix_ready = out_ready | ~out_valid. On input handshake
//   out_bit <= (pix_data >= threshold), out_valid <= 1 (latency 1). Held stable while
//   out_valid & ~out_ready. Input and output may handshake in the same cycle.
//   The output handshake of pixel FRAME_PIXELS -> done=1 that cycle, out_valid=0 next cycle,
//   -> IDLE (threshold kept).
// - Equal compare is inclusive: pixel == threshold -> 1. threshold 0 -> all ones.
// - pix_valid while pix_ready=0 is ignored (not consumed, no error).
// TESTING
// - Reset mid-ACCUM at pixel 100 -> all outputs 0 same cycle; a new start runs a full clean frame.
// - FRAME_PIXELS=16, pixels all 8'h40, thr_code=8'h40 -> 16 one-hot pulses, all on bit 64;
//   threshold=0x40; 16 out_bit=1; done once.
// - Pixels 0..15 with pix_valid every cycle -> cnt_inc_en bits 0..15 on consecutive cycles,
//   exactly one bit each, first 1 cycle after the first accept.
// - Sweep CLR_CYCLES=2 and SEARCH_LAT=3 -> cnt_clear high exactly 2 cycles. thr_code is sampled
//   exactly 3 cycles after FLUSH; a change one cycle earlier or later is not latched.
// - BIN with out_ready toggling 1010.. and random pix_valid -> no pixel dropped or duplicated,
//   out_bit stable while stalled, order preserved.
// - start pulsed during ACCUM/BIN -> ignored. Pixel 0x7F vs threshold 0x80 -> 0; 0x80 -> 1.

Source files
------------

// File: rtl/binarize_ctrl.sv
// Frame sequencer for histogram-threshold binarization: clears the bin counters, streams pass-1
// pixels as one-hot bin increments, latches the encoder threshold, then streams pass-2 binary pixels.
module binarize_ctrl #(
   parameter int unsigned FRAME_PIXELS = 4096,
   parameter int unsigned CNT_W        = 14,
   parameter int unsigned CLR_CYCLES   = 2,
   parameter int unsigned SEARCH_LAT   = 3
) (
   input  logic         clk,
   input  logic         clear_n,
   input  logic         start,
   input  logic         pix_valid,
   input  logic [7:0]   pix_data,
   output logic         pix_ready,
   output logic         cnt_clear,
   output logic [255:0] cnt_inc_en,
   input  logic [7:0]   thr_code,
   output logic         out_valid,
   output logic         out_bit,
   input  logic         out_ready,
   output logic [7:0]   threshold,
   output logic         busy,
   output logic         done
);

   localparam int unsigned PCNT_W  = $clog2(FRAME_PIXELS + 1);
   localparam int unsigned TMR_MAX = (CLR_CYCLES > SEARCH_LAT) ? CLR_CYCLES : SEARCH_LAT;
   localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

   localparam logic [PCNT_W-1:0] LAST_PIX  = PCNT_W'(FRAME_PIXELS - 1);
   localparam logic [PCNT_W-1:0] FULL_PIX  = PCNT_W'(FRAME_PIXELS);
   localparam logic [TMR_W-1:0]  CLR_LAST  = TMR_W'(CLR_CYCLES - 1);
   localparam logic [TMR_W-1:0]  SRCH_LAST = TMR_W'(SEARCH_LAT - 1);

   // Reject parameter sets the counter bank or the sequencer cannot honour.
   generate
      if (FRAME_PIXELS == 0 || FRAME_PIXELS >= (32'd1 << CNT_W)) begin : g_bad_frame
         $error("binarize_ctrl: FRAME_PIXELS must be nonzero and below 2**CNT_W");
      end
      if (CLR_CYCLES == 0 || SEARCH_LAT == 0) begin : g_bad_lat
         $error("binarize_ctrl: CLR_CYCLES and SEARCH_LAT must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_FLUSH,
      S_SEARCH,
      S_BIN
   } state_e;

   state_e              state_q;
   logic [PCNT_W-1:0]   pcnt_q;
   logic [TMR_W-1:0]    timer_q;
   logic                cnt_clear_q;
   logic [255:0]        cnt_inc_en_q;
   logic                out_valid_q;
   logic                out_bit_q;
   logic [7:0]          threshold_q;
   logic                busy_q;

   logic in_hs;
   logic out_hs;
   logic last_out;

   // In BIN the single output slot may refill in the same cycle it drains.
   assign pix_ready = (state_q == S_ACCUM) ||
                      ((state_q == S_BIN) && (pcnt_q != FULL_PIX) && (out_ready || !out_valid_q));
   assign in_hs     = pix_valid && pix_ready;
   assign out_hs    = out_valid_q && out_ready;
   assign last_out  = (state_q == S_BIN) && out_hs && (pcnt_q == FULL_PIX);

   assign cnt_clear  = cnt_clear_q;
   assign cnt_inc_en = cnt_inc_en_q;
   assign out_valid  = out_valid_q;
   assign out_bit    = out_bit_q;
   assign threshold  = threshold_q;
   assign busy       = busy_q;
   assign done       = last_out;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= S_IDLE;
         pcnt_q       <= '0;
         timer_q      <= '0;
         cnt_clear_q  <= 1'b0;
         cnt_inc_en_q <= '0;
         out_valid_q  <= 1'b0;
         out_bit_q    <= 1'b0;
         threshold_q  <= 8'h00;
         busy_q       <= 1'b0;
      end else begin
         cnt_inc_en_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q     <= S_CLEAR;
                  cnt_clear_q <= 1'b1;
                  timer_q     <= '0;
                  busy_q      <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (timer_q == CLR_LAST) begin
                  cnt_clear_q <= 1'b0;
                  pcnt_q      <= '0;
                  state_q     <= S_ACCUM;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            S_ACCUM: begin
               if (in_hs) begin
                  cnt_inc_en_q <= 256'(1) << pix_data;
                  pcnt_q       <= pcnt_q + PCNT_W'(1);
                  if (pcnt_q == LAST_PIX) begin
                     state_q <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               timer_q <= '0;
               state_q <= S_SEARCH;
            end
            S_SEARCH: begin
               if (timer_q == SRCH_LAST) begin
                  threshold_q <= thr_code;
                  pcnt_q      <= '0;
                  state_q     <= S_BIN;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            S_BIN: begin
               if (in_hs) begin
                  out_bit_q   <= (pix_data >= threshold_q);
                  out_valid_q <= 1'b1;
                  pcnt_q      <= pcnt_q + PCNT_W'(1);
               end else if (out_hs) begin
                  out_valid_q <= 1'b0;
               end
               if (last_out) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binarize_ctrl.sv
// Randomized self-checking bench for binarize_ctrl; a 16-pixel instance carries most scenarios and
// a 128-pixel instance covers the mid-frame reset.
module tb_binarize_ctrl;

   localparam int unsigned N_S  = 16;
   localparam int unsigned N_B  = 128;
   localparam int          MAXC = 4000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         clear_n_s, clear_n_b, start, sel_big;
   logic         pix_valid, out_ready;
   logic [7:0]   pix_data, thr_code;
   logic         s_start, b_start;

   logic         s_pix_ready, s_cnt_clear, s_out_valid, s_out_bit, s_busy, s_done;
   logic [255:0] s_inc;
   logic [7:0]   s_thr;
   logic         b_pix_ready, b_cnt_clear, b_out_valid, b_out_bit, b_busy, b_done;
   logic [255:0] b_inc;
   logic [7:0]   b_thr;

   logic         m_pix_ready, m_cnt_clear, m_out_valid, m_out_bit, m_busy, m_done;
   logic [255:0] m_inc;
   logic [7:0]   m_thr;

   assign s_start     = start & ~sel_big;
   assign b_start     = start & sel_big;
   assign m_pix_ready = sel_big ? b_pix_ready : s_pix_ready;
   assign m_cnt_clear = sel_big ? b_cnt_clear : s_cnt_clear;
   assign m_out_valid = sel_big ? b_out_valid : s_out_valid;
   assign m_out_bit   = sel_big ? b_out_bit   : s_out_bit;
   assign m_busy      = sel_big ? b_busy      : s_busy;
   assign m_done      = sel_big ? b_done      : s_done;
   assign m_inc       = sel_big ? b_inc       : s_inc;
   assign m_thr       = sel_big ? b_thr       : s_thr;

   binarize_ctrl #(.FRAME_PIXELS(N_S), .CNT_W(14), .CLR_CYCLES(2), .SEARCH_LAT(3)) u_dut (
      .clk(clk), .clear_n(clear_n_s), .start(s_start), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(s_pix_ready), .cnt_clear(s_cnt_clear), .cnt_inc_en(s_inc), .thr_code(thr_code),
      .out_valid(s_out_valid), .out_bit(s_out_bit), .out_ready(out_ready), .threshold(s_thr),
      .busy(s_busy), .done(s_done));

   binarize_ctrl #(.FRAME_PIXELS(N_B), .CNT_W(14), .CLR_CYCLES(2), .SEARCH_LAT(3)) u_big (
      .clk(clk), .clear_n(clear_n_b), .start(b_start), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(b_pix_ready), .cnt_clear(b_cnt_clear), .cnt_inc_en(b_inc), .thr_code(thr_code),
      .out_valid(b_out_valid), .out_bit(b_out_bit), .out_ready(out_ready), .threshold(b_thr),
      .busy(b_busy), .done(b_done));

   int checks;
   int errors;

   // Observations of one frame, filled by run_frame and judged by each test.
   logic [7:0]   src [0:255];
   int           acc_cyc [$];
   int           inc_cyc [$];
   logic [255:0] inc_val [$];
   int           clr_cyc [$];
   logic         out_bits [$];
   int           out_cyc [$];
   int           done_cyc [$];
   int           stall_viol, busy_gap, post_bad;
   logic         timeout;
   logic [7:0]   thr_log [0:MAXC-1];

   task automatic run_frame(input int n, input int valid_pct, input int ready_mode,
                            input bit thr_var, input logic [7:0] thr_const,
                            input bit glitch, input int abort_at);
      int idx, tail;
      bit finished, prev_ov, prev_or, prev_ob;
      acc_cyc.delete(); inc_cyc.delete(); inc_val.delete(); clr_cyc.delete();
      out_bits.delete(); out_cyc.delete(); done_cyc.delete();
      stall_viol = 0; busy_gap = 0; post_bad = 0; timeout = 1'b0;
      idx = 0; tail = -1; finished = 1'b0;
      prev_ov = 1'b0; prev_or = 1'b0; prev_ob = 1'b0;
      for (int cyc = 0; cyc < MAXC; cyc++) begin
         @(negedge clk);
         start     = (cyc == 0) ? 1'b1 : (glitch && tail < 0 && $urandom_range(0, 2) == 0);
         pix_valid = (idx < 2 * n) && ($urandom_range(1, 100) <= valid_pct);
         pix_data  = (idx < 2 * n) ? src[idx] : 8'h00;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         thr_code     = thr_var ? 8'(cyc * 37 + 11) : thr_const;
         thr_log[cyc] = thr_code;
         #1;
         if (tail >= 0) tail++;
         if (m_cnt_clear) clr_cyc.push_back(cyc);
         if (m_inc != '0) begin
            inc_cyc.push_back(cyc);
            inc_val.push_back(m_inc);
         end
         if (prev_ov && !prev_or && !(m_out_valid && m_out_bit == prev_ob)) stall_viol++;
         if (m_out_valid && out_ready) begin
            out_bits.push_back(m_out_bit);
            out_cyc.push_back(cyc);
         end
         if (m_done) done_cyc.push_back(cyc);
         if (tail < 0 && cyc >= 1 && !m_busy) busy_gap++;
         if (tail > 0 && (m_out_valid || m_busy)) post_bad++;
         if (pix_valid && m_pix_ready) begin
            acc_cyc.push_back(cyc);
            idx++;
         end
         prev_ov = m_out_valid; prev_or = out_ready; prev_ob = m_out_bit;
         if (m_done && tail < 0) tail = 0;
         if (tail == 2 || (abort_at > 0 && acc_cyc.size() == abort_at)) begin
            finished = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (abort_at == 0) pix_valid = 1'b0;
      if (!finished) timeout = 1'b1;
   endtask

   // Mismatches between observed bin enables and the pass-1 pixels accepted one cycle earlier.
   function automatic int inc_bad(input int n);
      int bad = 0;
      if (inc_val.size() != n || acc_cyc.size() < n) return 1000;
      for (int i = 0; i < n; i++) begin
         if (inc_val[i] !== (256'(1) << src[i]) || inc_cyc[i] != acc_cyc[i] + 1 ||
             $countones(inc_val[i]) != 1) bad++;
      end
      return bad;
   endfunction

   // Mismatches between observed binary pixels and pass-2 pixels compared to the threshold.
   function automatic int out_bad(input int n, input logic [7:0] thr);
      int bad = 0;
      if (out_bits.size() != n || acc_cyc.size() != 2 * n) return 1000;
      for (int i = 0; i < n; i++) begin
         if (out_bits[i] !== (src[n + i] >= thr)) bad++;
      end
      return bad;
   endfunction

   function automatic int done_skew(input int n);
      if (done_cyc.size() != 1 || out_cyc.size() != n) return -1;
      return done_cyc[0] - out_cyc[n - 1];
   endfunction

   task automatic test_reset;
      clear_n_s = 1'b0; clear_n_b = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({s_pix_ready, s_cnt_clear, s_out_valid, s_out_bit, s_busy, s_done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {s_pix_ready, s_cnt_clear, s_out_valid, s_out_bit, s_busy, s_done});
      end
      checks++;
      if (s_inc !== '0) begin errors++; $display("FAIL reset_inc: got %0h want 0", s_inc); end
      checks++;
      if (s_thr !== 8'h00) begin errors++; $display("FAIL reset_thr: got %0h want 0", s_thr); end
      @(negedge clk);
      clear_n_s = 1'b1; clear_n_b = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_flat_frame;
      for (int i = 0; i < 2 * N_S; i++) src[i] = 8'h40;
      run_frame(N_S, 100, 0, 1'b0, 8'h40, 1'b0, 0);
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL flat_timeout: got 1 want 0"); end
      checks++;
      if (inc_bad(N_S) != 0) begin errors++; $display("FAIL flat_inc: got %0d bad want 0", inc_bad(N_S)); end
      checks++;
      if (m_thr !== 8'h40) begin errors++; $display("FAIL flat_thr: got %0h want 40", m_thr); end
      checks++;
      if (out_bad(N_S, 8'h40) != 0) begin
         errors++; $display("FAIL flat_out: got %0d bad want 0", out_bad(N_S, 8'h40));
      end
      checks++;
      if (done_skew(N_S) != 0) begin errors++; $display("FAIL flat_done: got %0d want 0", done_skew(N_S)); end
      checks++;
      if (post_bad != 0) begin errors++; $display("FAIL flat_idle: got %0d want 0", post_bad); end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (m_thr !== 8'h40) begin errors++; $display("FAIL flat_thr_kept: got %0h want 40", m_thr); end
   endtask

   task automatic test_ramp_timing;
      logic [7:0] exp_thr;
      for (int i = 0; i < N_S; i++) src[i] = 8'(i);
      for (int i = N_S; i < 2 * N_S; i++) src[i] = 8'($urandom);
      run_frame(N_S, 100, 0, 1'b1, 8'h00, 1'b0, 0);
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL ramp_timeout: got 1 want 0"); end
      checks++;
      if (inc_bad(N_S) != 0) begin errors++; $display("FAIL ramp_inc: got %0d bad want 0", inc_bad(N_S)); end
      checks++;
      if (acc_cyc.size() < N_S || acc_cyc[N_S - 1] - acc_cyc[0] != N_S - 1) begin
         errors++; $display("FAIL ramp_consecutive: got %0d accepts want %0d back-to-back", acc_cyc.size(), N_S);
      end
      checks++;
      if (clr_cyc.size() != 2 || clr_cyc[0] != 1 || clr_cyc[1] != 2) begin
         errors++; $display("FAIL ramp_clear: got %0d cycles want 2 at cycles 1,2", clr_cyc.size());
      end
      checks++;
      if (acc_cyc.size() == 0 || acc_cyc[0] != 3) begin
         errors++; $display("FAIL ramp_first_accept: got %0d want 3", (acc_cyc.size() > 0) ? acc_cyc[0] : -1);
      end
      exp_thr = (acc_cyc.size() >= N_S) ? thr_log[acc_cyc[N_S - 1] + 4] : 8'h00;
      checks++;
      if (m_thr !== exp_thr) begin errors++; $display("FAIL ramp_thr_sample: got %0h want %0h", m_thr, exp_thr); end
      checks++;
      if (out_bad(N_S, exp_thr) != 0) begin
         errors++; $display("FAIL ramp_out: got %0d bad want 0", out_bad(N_S, exp_thr));
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] thr;
      for (int mode = 1; mode <= 2; mode++) begin
         thr = 8'($urandom_range(20, 230));
         for (int i = 0; i < 2 * N_S; i++) src[i] = 8'($urandom);
         run_frame(N_S, 60, mode, 1'b0, thr, 1'b0, 0);
         checks++;
         if (timeout !== 1'b0) begin errors++; $display("FAIL bp%0d_timeout: got 1 want 0", mode); end
         checks++;
         if (inc_bad(N_S) != 0) begin errors++; $display("FAIL bp%0d_inc: got %0d bad want 0", mode, inc_bad(N_S)); end
         checks++;
         if (stall_viol != 0) begin errors++; $display("FAIL bp%0d_stall: got %0d want 0", mode, stall_viol); end
         checks++;
         if (out_bad(N_S, thr) != 0) begin
            errors++; $display("FAIL bp%0d_out: got %0d bad want 0", mode, out_bad(N_S, thr));
         end
         checks++;
         if (done_skew(N_S) != 0) begin errors++; $display("FAIL bp%0d_done: got %0d want 0", mode, done_skew(N_S)); end
      end
   endtask

   task automatic test_start_ignored;
      logic [7:0] thr;
      thr = 8'($urandom_range(20, 230));
      for (int i = 0; i < 2 * N_S; i++) src[i] = 8'($urandom);
      run_frame(N_S, 70, 2, 1'b0, thr, 1'b1, 0);
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL glitch_timeout: got 1 want 0"); end
      checks++;
      if (busy_gap != 0 || clr_cyc.size() != 2) begin
         errors++; $display("FAIL glitch_restart: got busy_gap %0d clears %0d want 0 and 2", busy_gap, clr_cyc.size());
      end
      checks++;
      if (inc_bad(N_S) != 0) begin errors++; $display("FAIL glitch_inc: got %0d bad want 0", inc_bad(N_S)); end
      checks++;
      if (out_bad(N_S, thr) != 0) begin
         errors++; $display("FAIL glitch_out: got %0d bad want 0", out_bad(N_S, thr));
      end
      checks++;
      if (done_skew(N_S) != 0 || post_bad != 0) begin
         errors++; $display("FAIL glitch_done: got skew %0d post %0d want 0 0", done_skew(N_S), post_bad);
      end
   endtask

   task automatic test_compare_edges;
      logic [7:0] tbl [0:15];
      int ones;
      tbl = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h80, 8'h7F,
              8'h01, 8'hFE, 8'h80, 8'h40, 8'hC0, 8'h7F, 8'h80, 8'h80};
      for (int i = 0; i < N_S; i++) begin
         src[i]       = 8'($urandom);
         src[N_S + i] = tbl[i];
      end
      run_frame(N_S, 100, 2, 1'b0, 8'h80, 1'b0, 0);
      checks++;
      if (out_bits.size() != N_S || out_bits[0] !== 1'b0 || out_bits[1] !== 1'b1) begin
         errors++; $display("FAIL edge_7f_80: got %0d outputs want 16 with 0x7F->0 0x80->1", out_bits.size());
      end
      checks++;
      if (out_bad(N_S, 8'h80) != 0) begin
         errors++; $display("FAIL edge_table: got %0d bad want 0", out_bad(N_S, 8'h80));
      end
      for (int i = 0; i < 2 * N_S; i++) src[i] = 8'($urandom);
      run_frame(N_S, 80, 0, 1'b0, 8'h00, 1'b0, 0);
      ones = 0;
      foreach (out_bits[i]) if (out_bits[i] === 1'b1) ones++;
      checks++;
      if (ones != N_S || timeout !== 1'b0) begin
         errors++; $display("FAIL edge_thr0: got %0d ones want %0d", ones, N_S);
      end
   endtask

   task automatic test_reset_mid_accum;
      logic [7:0] thr;
      sel_big = 1'b1;
      thr = 8'($urandom_range(20, 230));
      for (int i = 0; i < 2 * N_B; i++) src[i] = 8'($urandom);
      run_frame(N_B, 100, 0, 1'b0, thr, 1'b0, 100);
      @(negedge clk);
      pix_valid = 1'b0;
      #1;
      checks++;
      if (acc_cyc.size() != 100 || b_inc !== (256'(1) << src[99]) || b_busy !== 1'b1) begin
         errors++; $display("FAIL abort_setup: got accepts %0d inc %0h want 100 and bin %0d", acc_cyc.size(), b_inc, src[99]);
      end
      clear_n_b = 1'b0;
      #1;
      checks++;
      if ({b_pix_ready, b_cnt_clear, b_out_valid, b_out_bit, b_busy, b_done} !== 6'b0 || b_inc !== '0 || b_thr !== 8'h00) begin
         errors++; $display("FAIL abort_outputs: got ctrl %b inc %0h thr %0h want all 0",
                            {b_pix_ready, b_cnt_clear, b_out_valid, b_out_bit, b_busy, b_done}, b_inc, b_thr);
      end
      @(negedge clk);
      clear_n_b = 1'b1;
      repeat (2) @(negedge clk);
      thr = 8'($urandom_range(20, 230));
      for (int i = 0; i < 2 * N_B; i++) src[i] = 8'($urandom);
      run_frame(N_B, 90, 2, 1'b0, thr, 1'b0, 0);
      checks++;
      if (timeout !== 1'b0 || clr_cyc.size() != 2) begin
         errors++; $display("FAIL rerun_seq: got timeout %0d clears %0d want 0 2", timeout, clr_cyc.size());
      end
      checks++;
      if (inc_bad(N_B) != 0) begin errors++; $display("FAIL rerun_inc: got %0d bad want 0", inc_bad(N_B)); end
      checks++;
      if (m_thr !== thr || out_bad(N_B, thr) != 0) begin
         errors++; $display("FAIL rerun_out: got thr %0h bad %0d want %0h 0", m_thr, out_bad(N_B, thr), thr);
      end
      checks++;
      if (done_skew(N_B) != 0) begin errors++; $display("FAIL rerun_done: got %0d want 0", done_skew(N_B)); end
      sel_big = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      clear_n_s = 1'b0; clear_n_b = 1'b0; start = 1'b0; sel_big = 1'b0;
      pix_valid = 1'b0; pix_data = 8'h00; out_ready = 1'b0; thr_code = 8'h00;
      test_reset;
      test_flat_frame;
      test_ramp_timing;
      test_back_to_back;
      test_start_ignored;
      test_compare_edges;
      test_reset_mid_accum;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
